// File: rtl/serial_sync_pkg.sv
// Shared definitions for the serial sync link: frame FSM states and the
// default sync header, used by both the transmitter and the detector side.
package serial_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int                    SYNC_W_DEF   = 4;
  localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 4'b1011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register; sout always presents the current MSB,
// and each shift moves the next lower bit into view.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] pin,
  output logic             sout
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // load wins over shift so a fresh word is never disturbed on its load edge
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = pin;
    end else if (shift) begin
      data_d = data_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign sout = data_q[WIDTH-1];

endmodule

// File: rtl/serial_sync_tx.sv
// Frame transmitter: sync header, MSB-first payload, then an idle gap,
// all on one registered serial line.
module serial_sync_tx
  import serial_sync_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
  parameter int                GAP_LEN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              sync_act,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_LEN) + 1);

  state_e           state_q;
  logic [CNT_W-1:0] bitCnt_q;
  logic             dout_q;
  logic             syncAct_q;
  logic             busy_q;
  logic             done_q;
  logic             inReady_q;

  logic             accept;
  logic             hdrShift;
  logic             payShift;
  logic             hdrSout;
  logic             paySout;
  logic [SYNC_W-1:0] hdrPin;

  // dout_q is loaded one bit ahead, so the header shifter starts at the
  // second header bit; the first one is driven straight from SYNC_PAT
  assign hdrPin   = SYNC_PAT << 1;
  assign accept   = (state_q == IDLE) && in_valid;
  assign hdrShift = (state_q == SYNC);
  assign payShift = ((state_q == SYNC) && (bitCnt_q == CNT_W'(1))) || (state_q == DATA);

  piso_shift #(.WIDTH(SYNC_W)) uHdr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (hdrShift),
    .pin   (hdrPin),
    .sout  (hdrSout)
  );

  piso_shift #(.WIDTH(DATA_W)) uPay (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (payShift),
    .pin   (in_data),
    .sout  (paySout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      dout_q    <= 1'b0;
      syncAct_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inReady_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          dout_q <= 1'b0;
          if (in_valid) begin
            state_q   <= SYNC;
            bitCnt_q  <= CNT_W'(SYNC_W);
            dout_q    <= SYNC_PAT[SYNC_W-1];
            syncAct_q <= 1'b1;
            busy_q    <= 1'b1;
            inReady_q <= 1'b0;
          end
        end
        SYNC: begin
          if (bitCnt_q == CNT_W'(1)) begin
            state_q   <= DATA;
            bitCnt_q  <= CNT_W'(DATA_W);
            dout_q    <= paySout;
            syncAct_q <= 1'b0;
          end else begin
            bitCnt_q <= bitCnt_q - CNT_W'(1);
            dout_q   <= hdrSout;
          end
        end
        DATA: begin
          if (bitCnt_q == CNT_W'(1)) begin
            state_q  <= GAP;
            bitCnt_q <= CNT_W'(GAP_LEN);
            dout_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            bitCnt_q <= bitCnt_q - CNT_W'(1);
            dout_q   <= paySout;
          end
        end
        GAP: begin
          dout_q <= 1'b0;
          if (bitCnt_q == CNT_W'(1)) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            busy_q    <= 1'b0;
            inReady_q <= 1'b1;
          end else begin
            bitCnt_q <= bitCnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          bitCnt_q  <= '0;
          dout_q    <= 1'b0;
          syncAct_q <= 1'b0;
          busy_q    <= 1'b0;
          inReady_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = inReady_q;
  assign dout     = dout_q;
  assign sync_act = syncAct_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
